seg_scan_sched: RTL and testbench
=================================

# seg_scan_sched

Scan scheduler and display-buffer controller for the 8-digit multiplexed seven-segment display. It holds an 8-entry digit buffer and accepts digit writes from a host over a valid/ready handshake. It time-multiplexes the buffer onto the one-hot digit-select and segment outputs at a fixed dwell rate, and can optionally rotate the displayed pattern one position per scroll interval. It sits between the board clock and the display pins and replaces free-running divider/scan logic with a single-clock, reset-clean controller.

## Interface
- DWELL_CYC, 5000: clk cycles per digit dwell; sets the scan rate; must be ≥2.
- SHIFT_TICKS, 10000: dwell ticks per rotation step; must be ≥1.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  host write request.
- wr_ready  out  1  write accepted when high together with wr_valid; combinational.
- wr_idx  in  3  buffer index to write; 0 maps to the leftmost digit.
- wr_code  in  5  bit4 = blank; bits[3:0] = hex value 0–F.
- clr  in  1  single-cycle pulse that starts a buffer clear.
- rot_en  in  1  enables rotation; level-sensitive.
- an  out  8  one-hot digit select, active-high; position 0 = 8'b1000_0000.
- seg  out  14  segments {a,b,c,d,e,f,g}, active-high; bits[13:7] duplicate bits[6:0].
- busy  out  1  high while a clear is in progress.

## Operation
- State machine states:
  - RUN: scanning; writes are allowed.
  - CLEAR: writes the blank code to buffer entries 0..7, one entry per cycle, for 8 cycles, then returns to RUN. Scanning continues during CLEAR.
- Transitions:
  - RUN→CLEAR when clr=1.
  - clr during CLEAR restarts the clear index at 0.
- wr_ready = (state==RUN) && !clr.
- When wr_valid && wr_ready: buf[wr_idx] ← wr_code on that edge.
- Simultaneous clr and wr_valid: clr wins and the write is not accepted.
- Dwell counter counts 0..DWELL_CYC-1. A tick occurs at DWELL_CYC-1; on a tick, sel ← sel+1 (3-bit, wraps 7→0).
- Scroll counter advances only on ticks while rot_en=1. On a tick with scroll count = SHIFT_TICKS-1 and rot_en=1: off ← off+1 (mod 8) and the scroll count resets to 0. rot_en=0 holds both the scroll count and off.
- Displayed entry is buf[(sel+off) mod 8] (3-bit add, natural wrap).
- A write and a rotation step in the same cycle both take effect. Writes use the absolute index and are unaffected by off.
- Decode, bits {a..g}:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - blank=0000000.

## Timing
- Reset (asynchronous, immediate):
  - an=8'h00, seg=0, busy=0, state=RUN.
  - sel=0, off=0, both counters=0, all buffer entries blank.
- an and seg are registered from the current sel/off/buf, so they lag state by exactly 1 cycle.
- The first non-zero an appears 1 cycle after reset release.
- A write lands on edge N. If its digit is currently selected, seg reflects it at edge N+1.
- sel changes on a tick edge; an changes on the following edge. Every digit dwells exactly DWELL_CYC cycles.
- busy rises on the edge after clr and falls after the 8th clear write. After clr, wr_ready returns high on cycle 9.
- A rotation step is visible on the edge after the tick that caused it.
- Asserting rst_n low mid-clear or mid-dwell aborts everything to the reset values.

## Structure
- Shared package holds:
  - the segment code constants (SEG_0..SEG_F, SEG_BLANK),
  - the state enum {RUN, CLEAR},
  - the code field widths (CODE_W=5, BLANK_BIT=4).
- One sub-module: seg7_decode, a purely combinational 5-bit code → 7-bit segment map. It is instantiated once and its output is registered in the parent.

## Test plan
All scenarios use DWELL_CYC=4 and SHIFT_TICKS=3.
- Reset then idle: an sequences 80,40,20,10,08,04,02,01 at 4 cycles each, then wraps; seg=0 throughout.
- Write 6,8,0,1,1,0,0,2 to idx 0..7: seg = 1011111_1011111 while an=80, and 1101101_1101101 while an=01.
- Write idx 3 = code 5 while digit 3 is selected: seg = 1011011 in both halves on the next cycle.
- rot_en=1 after loading 0..7: after 3 ticks, an=80 shows digit value 1; after 24 ticks off wraps to 0 and an=80 shows 0.
- clr with wr_valid in the same cycle: write not accepted; wr_ready=0 for 9 cycles; busy high 8 cycles; all digits then show blank.
- rst_n pulsed low during CLEAR and rotation: outputs 0 immediately; restart from sel=0, off=0, all digits blank.

Source files
------------

// File: rtl/seg_scan_sched_pkg.sv
// Shared definitions for the seven-segment scan scheduler: code field layout,
// segment patterns in {a,b,c,d,e,f,g} order (a is the MSB), and FSM states.
package seg_scan_sched_pkg;

    localparam int CODE_W     = 5;
    localparam int BLANK_BIT  = 4;
    localparam int SEG_W      = 7;
    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b1000111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

    // Buffer code that renders as an unlit digit.
    localparam logic [CODE_W-1:0] CODE_BLANK = 5'b10000;

    typedef enum logic {
        RUN,
        CLEAR
    } state_t;

    // Digit position 0 is the leftmost digit, driven by the MSB of the select.
    function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] pos);
        return 8'h80 >> pos;
    endfunction

endpackage

// File: rtl/seg_scan_sched_seg7_decode.sv
// Combinational map from a 5-bit display code (blank flag + hex nibble) to
// the seven segment lines {a,b,c,d,e,f,g}, active-high.
module seg7_decode
    import seg_scan_sched_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SEG_W-1:0]  seg
);

    // Blank flag overrides the nibble; otherwise a plain hex lookup.
    always_comb begin
        seg = SEG_BLANK;
        if (!code[BLANK_BIT]) begin
            case (code[3:0])
                4'h0: seg = SEG_0;
                4'h1: seg = SEG_1;
                4'h2: seg = SEG_2;
                4'h3: seg = SEG_3;
                4'h4: seg = SEG_4;
                4'h5: seg = SEG_5;
                4'h6: seg = SEG_6;
                4'h7: seg = SEG_7;
                4'h8: seg = SEG_8;
                4'h9: seg = SEG_9;
                4'hA: seg = SEG_A;
                4'hB: seg = SEG_B;
                4'hC: seg = SEG_C;
                4'hD: seg = SEG_D;
                4'hE: seg = SEG_E;
                default: seg = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_sched.sv
// Scan scheduler and display-buffer controller for an 8-digit multiplexed
// seven-segment display: host-writable digit buffer, timed digit scan,
// optional rotation, and a sequenced buffer clear.
module seg_scan_sched
    import seg_scan_sched_pkg::*;
#(
    parameter int DWELL_CYC   = 5000,
    parameter int SHIFT_TICKS = 10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_idx,
    input  logic [4:0]  wr_code,
    input  logic        clr,
    input  logic        rot_en,
    output logic [7:0]  an,
    output logic [13:0] seg,
    output logic        busy
);

    localparam int DW_W = (DWELL_CYC   > 2) ? $clog2(DWELL_CYC)   : 1;
    localparam int SC_W = (SHIFT_TICKS > 1) ? $clog2(SHIFT_TICKS) : 1;

    state_t              state;
    logic [IDX_W-1:0]    clr_idx;
    logic [CODE_W-1:0]   digit_buf [NUM_DIGITS];

    logic [DW_W-1:0]     dwell_cnt;
    logic [SC_W-1:0]     scroll_cnt;
    logic [IDX_W-1:0]    sel;
    logic [IDX_W-1:0]    off;

    logic                tick;
    logic                wr_fire;
    logic [IDX_W-1:0]    rd_idx;
    logic [CODE_W-1:0]   rd_code;
    logic [SEG_W-1:0]    dec_seg;

    assign wr_ready = (state == RUN) && !clr;
    assign wr_fire  = wr_valid && wr_ready;
    assign tick     = (dwell_cnt == DW_W'(DWELL_CYC - 1));
    assign rd_idx   = sel + off;
    assign rd_code  = digit_buf[rd_idx];

    seg7_decode u_decode (
        .code (rd_code),
        .seg  (dec_seg)
    );

    // Clear sequencer: RUN until clr, then walk entries 0..7; a repeated clr restarts the walk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            clr_idx <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (clr) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                        busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr) begin
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + 3'd1;
                        if (clr_idx == 3'd7) begin
                            state <= RUN;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Digit buffer: host writes only in RUN, sequenced blanking only in CLEAR, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                digit_buf[i] <= CODE_BLANK;
            end
        end else if (wr_fire) begin
            digit_buf[wr_idx] <= wr_code;
        end else if ((state == CLEAR) && !clr) begin
            digit_buf[clr_idx] <= CODE_BLANK;
        end
    end

    // Dwell timer: every DWELL_CYC cycles advance the scanned digit position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_cnt <= '0;
            sel       <= '0;
        end else if (tick) begin
            dwell_cnt <= '0;
            sel       <= sel + 3'd1;
        end else begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
        end
    end

    // Rotation: count ticks while enabled, step the display offset every SHIFT_TICKS ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scroll_cnt <= '0;
            off        <= '0;
        end else if (tick && rot_en) begin
            if (scroll_cnt == SC_W'(SHIFT_TICKS - 1)) begin
                scroll_cnt <= '0;
                off        <= off + 3'd1;
            end else begin
                scroll_cnt <= scroll_cnt + SC_W'(1);
            end
        end
    end

    // Output registers: digit select and both segment halves from the current scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '0;
            seg <= '0;
        end else begin
            an  <= digit_onehot(sel);
            seg <= {dec_seg, dec_seg};
        end
    end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Scoreboard bench for seg_scan_sched with DWELL_CYC=4, SHIFT_TICKS=3.
// Stimulus pushes hand-computed expectations keyed by cycle number (edges
// since reset release); a monitor on the falling edge pops and compares them.
module tb_seg_scan_sched;

    localparam int DW = 4;
    localparam int ST = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [2:0]  wr_idx = '0;
    logic [4:0]  wr_code = '0;
    logic        clr = 1'b0;
    logic        rot_en = 1'b0;
    logic        wr_ready;
    logic [7:0]  an;
    logic [13:0] seg;
    logic        busy;

    seg_scan_sched #(.DWELL_CYC(DW), .SHIFT_TICKS(ST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_idx   (wr_idx),
        .wr_code  (wr_code),
        .clr      (clr),
        .rot_en   (rot_en),
        .an       (an),
        .seg      (seg),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef enum int {S_AN, S_SEG, S_BUSY, S_RDY} sig_t;
    typedef struct {
        int unsigned cyc;
        sig_t        sig;
        logic [13:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [13:0] actual_of(input sig_t s);
        case (s)
            S_AN:    return {6'b0, an};
            S_SEG:   return seg;
            S_BUSY:  return {13'b0, busy};
            default: return {13'b0, wr_ready};
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle; flag any that were skipped.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                n_checks++;
                if (actual_of(sb[i].sig) !== sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%h want=%h",
                             sb[i].sig.name(), cyc, actual_of(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed_%s cyc=%0d got=none want=%h",
                         sb[i].sig.name(), sb[i].cyc, sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic exp_an(input int unsigned c, input logic [7:0] v);
        sb.push_back('{c, S_AN, {6'b0, v}});
    endtask

    task automatic exp_seg(input int unsigned c, input logic [6:0] v);
        sb.push_back('{c, S_SEG, {v, v}});
    endtask

    task automatic exp_busy(input int unsigned c, input logic v);
        sb.push_back('{c, S_BUSY, {13'b0, v}});
    endtask

    task automatic exp_rdy(input int unsigned c, input logic v);
        sb.push_back('{c, S_RDY, {13'b0, v}});
    endtask

    // Select shown at cycle c reflects the scan position one edge earlier.
    function automatic logic [7:0] an_for(input int unsigned c);
        return 8'h80 >> (((c - 1) / 4) % 8);
    endfunction

    task automatic wait_cyc(input int unsigned n);
        int unsigned guard;
        guard = 0;
        while (cyc != n && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_cyc got=%0d want=%0d", cyc, n);
        end
    endtask

    initial begin
        int s2[8];
        int unsigned g;
        s2 = '{6, 8, 0, 1, 1, 0, 0, 2};

        // Reset state.
        exp_an(0, 8'h00); exp_seg(0, 7'b0); exp_busy(0, 1'b0); exp_rdy(0, 1'b1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle scan: 80,40,...,01 at 4 cycles each then wrap, all blank.
        for (int unsigned c = 1; c <= 36; c++) begin
            exp_an(c, an_for(c));
            exp_seg(c, 7'b0000000);
        end

        // Load 6,8,0,1,1,0,0,2 into idx 0..7 (lands on edges 41..48).
        wait_cyc(40);
        exp_rdy(40, 1'b1);
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_idx   = 3'(i);
            wr_code  = {1'b0, 4'(s2[i])};
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        for (int unsigned c = 61; c <= 64; c++) begin
            exp_an(c, 8'h01); exp_seg(c, 7'b1101101);
        end
        for (int unsigned c = 65; c <= 68; c++) begin
            exp_an(c, 8'h80); exp_seg(c, 7'b1011111);
        end
        exp_an(69, 8'h40); exp_seg(69, 7'b1111111);

        // Write idx 3 = 5 while digit 3 is scanned: old value, then new one edge later.
        wait_cyc(76);
        wr_valid = 1'b1; wr_idx = 3'd3; wr_code = 5'h05;
        exp_an(77, 8'h10); exp_seg(77, 7'b0110000);
        exp_an(78, 8'h10); exp_seg(78, 7'b1011011);
        @(posedge clk); #1;
        wr_valid = 1'b0;

        // Load 0..7 then rotate; ticks with rot_en at edges 112,116,...; steps at 120+12k.
        wait_cyc(100);
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_idx   = 3'(i);
            wr_code  = 5'(i);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        rot_en   = 1'b1;
        exp_an(120, 8'h04); exp_seg(120, 7'b1011011);
        exp_an(121, 8'h02); exp_seg(121, 7'b1110000);
        for (int unsigned c = 129; c <= 132; c++) begin
            exp_an(c, 8'h80); exp_seg(c, 7'b0110000);
        end
        exp_an(204, 8'h20); exp_seg(204, 7'b0110000);
        exp_an(205, 8'h10); exp_seg(205, 7'b1111001);
        exp_an(225, 8'h80); exp_seg(225, 7'b1111110);
        wait_cyc(205);
        rot_en = 1'b0;

        // clr together with a write to idx 0: write dropped, 8-cycle clear.
        wait_cyc(255);
        clr = 1'b1; wr_valid = 1'b1; wr_idx = 3'd0; wr_code = 5'h0F;
        exp_rdy(255, 1'b0); exp_busy(255, 1'b0);
        for (int unsigned c = 256; c <= 263; c++) begin
            exp_rdy(c, 1'b0); exp_busy(c, 1'b1);
        end
        exp_rdy(264, 1'b1); exp_busy(264, 1'b0);
        exp_an(257, 8'h80); exp_seg(257, 7'b1111110);
        exp_an(258, 8'h80); exp_seg(258, 7'b0000000);
        for (int unsigned k = 0; k < 8; k++) begin
            exp_an(268 + 4 * k, an_for(268 + 4 * k));
            exp_seg(268 + 4 * k, 7'b0000000);
        end
        @(posedge clk); #1;
        clr = 1'b0; wr_valid = 1'b0;

        // Reset during a clear with rotation active.
        wait_cyc(300);
        rot_en = 1'b1;
        wait_cyc(305);
        wr_valid = 1'b1; wr_idx = 3'd0; wr_code = 5'h08;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wait_cyc(320);
        clr = 1'b1;
        exp_busy(322, 1'b1);
        @(posedge clk); #1;
        clr = 1'b0;
        wait_cyc(323);
        rst_n  = 1'b0;
        rot_en = 1'b0;
        exp_an(0, 8'h00); exp_seg(0, 7'b0); exp_busy(0, 1'b0); exp_rdy(0, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int unsigned c = 1; c <= 8; c++) begin
            exp_an(c, an_for(c));
            exp_seg(c, 7'b0000000);
        end
        exp_busy(1, 1'b0); exp_rdy(1, 1'b1);
        wait_cyc(10);
        wr_valid = 1'b1; wr_idx = 3'd0; wr_code = 5'h08;
        exp_an(33, 8'h80); exp_seg(33, 7'b1111111);
        exp_an(34, 8'h80); exp_seg(34, 7'b1111111);
        @(posedge clk); #1;
        wr_valid = 1'b0;

        g = 0;
        while (sb.size() > 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        @(posedge clk);
        while (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pending_%s cyc=%0d got=none want=%h",
                     sb[0].sig.name(), sb[0].cyc, sb[0].val);
            void'(sb.pop_front());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
